// File: rtl/alpha_calc_ctrl_if.sv
// Valid/ready/data stream bundle used for every stream port of alpha_calc_ctrl.
// The master drives valid/data, the slave drives ready.
interface alpha_calc_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/alpha_calc_ctrl.sv
// Sequences means, sample streams and alpha results between upstream sources and one alpha_calc.
// Optional stall counter enabled by defining ALPHA_CALC_CTRL_STATS_EN.
module alpha_calc_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int BLOCK_SIZE_LOG = 8,
  parameter int ALPHA_WIDTH    = 10,
  parameter int BLOCKS_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BLOCKS_WIDTH-1:0] cfg_blocks,
  output logic                    busy,
  output logic                    done,
  alpha_calc_ctrl_if.slave        in_x,
  alpha_calc_ctrl_if.slave        in_xhat,
  alpha_calc_ctrl_if.slave        in_xmean,
  alpha_calc_ctrl_if.slave        in_xhatmean,
  alpha_calc_ctrl_if.master       calc_x,
  alpha_calc_ctrl_if.master       calc_xhat,
  alpha_calc_ctrl_if.master       calc_xmean,
  alpha_calc_ctrl_if.master       calc_xhatmean,
  alpha_calc_ctrl_if.slave        calc_alpha,
  alpha_calc_ctrl_if.master       alpha,
  output logic                    alpha_last
`ifdef ALPHA_CALC_CTRL_STATS_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int CW = BLOCK_SIZE_LOG + 1;
  localparam logic [CW-1:0] N_SAMPLES = {1'b1, {BLOCK_SIZE_LOG{1'b0}}};

  typedef enum logic [2:0] {IDLE, MEANS, STREAM, ALPHA, DONE} state_e;

  state_e                  state;
  logic [BLOCKS_WIDTH-1:0] cfg_q;
  logic [BLOCKS_WIDTH-1:0] blk_idx;
  logic                    xmean_taken, xhatmean_taken;
  logic [CW-1:0]           cnt_x, cnt_xhat;

  // Gates decode registered state only, so streams add no latency and no comb loops.
  logic g_xmean, g_xhatmean, g_x, g_xhat, g_alpha;
  assign g_xmean    = (state == MEANS)  && !xmean_taken;
  assign g_xhatmean = (state == MEANS)  && !xhatmean_taken;
  assign g_x        = (state == STREAM) && (cnt_x    != N_SAMPLES);
  assign g_xhat     = (state == STREAM) && (cnt_xhat != N_SAMPLES);
  assign g_alpha    = (state == ALPHA);

  assign calc_xmean.valid    = g_xmean    & in_xmean.valid;
  assign in_xmean.ready      = g_xmean    & calc_xmean.ready;
  assign calc_xmean.data     = in_xmean.data[DATA_WIDTH-1:0];
  assign calc_xhatmean.valid = g_xhatmean & in_xhatmean.valid;
  assign in_xhatmean.ready   = g_xhatmean & calc_xhatmean.ready;
  assign calc_xhatmean.data  = in_xhatmean.data[DATA_WIDTH-1:0];
  assign calc_x.valid        = g_x        & in_x.valid;
  assign in_x.ready          = g_x        & calc_x.ready;
  assign calc_x.data         = in_x.data[DATA_WIDTH-1:0];
  assign calc_xhat.valid     = g_xhat     & in_xhat.valid;
  assign in_xhat.ready       = g_xhat     & calc_xhat.ready;
  assign calc_xhat.data      = in_xhat.data[DATA_WIDTH-1:0];

  logic is_last;
  assign is_last     = (blk_idx == cfg_q - BLOCKS_WIDTH'(1));
  assign alpha.valid = g_alpha & calc_alpha.valid;
  assign calc_alpha.ready = g_alpha & alpha.ready;
  assign alpha.data  = calc_alpha.data[ALPHA_WIDTH-1:0];
  assign alpha_last  = g_alpha & is_last;

  logic xmean_fire, xhatmean_fire, x_fire, xhat_fire, alpha_fire;
  assign xmean_fire    = calc_xmean.valid    & calc_xmean.ready;
  assign xhatmean_fire = calc_xhatmean.valid & calc_xhatmean.ready;
  assign x_fire        = calc_x.valid        & calc_x.ready;
  assign xhat_fire     = calc_xhat.valid     & calc_xhat.ready;
  assign alpha_fire    = alpha.valid         & alpha.ready;

  logic          xmean_got, xhatmean_got;
  logic [CW-1:0] cnt_x_nxt, cnt_xhat_nxt;
  assign xmean_got    = xmean_taken    | xmean_fire;
  assign xhatmean_got = xhatmean_taken | xhatmean_fire;
  assign cnt_x_nxt    = cnt_x    + {{(CW-1){1'b0}}, x_fire};
  assign cnt_xhat_nxt = cnt_xhat + {{(CW-1){1'b0}}, xhat_fire};

  // NOTE: every register here uses <= so all updates see pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: all control state is reset; a partial job is discarded, not resumed.
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      cfg_q          <= '0;
      blk_idx        <= '0;
      xmean_taken    <= 1'b0;
      xhatmean_taken <= 1'b0;
      cnt_x          <= '0;
      cnt_xhat       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cfg_q   <= cfg_blocks;
            blk_idx <= '0;
            busy    <= 1'b1;
            if (cfg_blocks == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= MEANS;
            end
          end
        end
        MEANS: begin
          if (xmean_got && xhatmean_got) begin
            xmean_taken    <= 1'b0;
            xhatmean_taken <= 1'b0;
            state          <= STREAM;
          end else begin
            xmean_taken    <= xmean_got;
            xhatmean_taken <= xhatmean_got;
          end
        end
        STREAM: begin
          if (cnt_x_nxt == N_SAMPLES && cnt_xhat_nxt == N_SAMPLES) begin
            cnt_x    <= '0;
            cnt_xhat <= '0;
            state    <= ALPHA;
          end else begin
            cnt_x    <= cnt_x_nxt;
            cnt_xhat <= cnt_xhat_nxt;
          end
        end
        ALPHA: begin
          if (alpha_fire) begin
            if (is_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              blk_idx <= blk_idx + BLOCKS_WIDTH'(1);
              state   <= MEANS;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALPHA_CALC_CTRL_STATS_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state == IDLE && start) begin
      stall_q <= '0;
    end else if (state == STREAM && !x_fire && !xhat_fire && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_alpha_calc_ctrl.sv
// Scoreboard bench for alpha_calc_ctrl with N=4 samples per block; models sources, alpha_calc and sink.
// Define ALPHA_CALC_CTRL_STATS_EN to also check stall_cycles.
module tb_alpha_calc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_blocks;
  logic        busy, done, alpha_last;
`ifdef ALPHA_CALC_CTRL_STATS_EN
  logic [31:0] stall_cycles;
  int          exp_stall;
`endif

  alpha_calc_ctrl_if #(.WIDTH(16)) in_x ();
  alpha_calc_ctrl_if #(.WIDTH(16)) in_xhat ();
  alpha_calc_ctrl_if #(.WIDTH(16)) in_xmean ();
  alpha_calc_ctrl_if #(.WIDTH(16)) in_xhatmean ();
  alpha_calc_ctrl_if #(.WIDTH(16)) calc_x ();
  alpha_calc_ctrl_if #(.WIDTH(16)) calc_xhat ();
  alpha_calc_ctrl_if #(.WIDTH(16)) calc_xmean ();
  alpha_calc_ctrl_if #(.WIDTH(16)) calc_xhatmean ();
  alpha_calc_ctrl_if #(.WIDTH(10)) calc_alpha ();
  alpha_calc_ctrl_if #(.WIDTH(10)) alpha ();

  alpha_calc_ctrl #(
    .DATA_WIDTH(16), .BLOCK_SIZE_LOG(2), .ALPHA_WIDTH(10), .BLOCKS_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_blocks(cfg_blocks),
    .busy(busy), .done(done),
    .in_x(in_x), .in_xhat(in_xhat), .in_xmean(in_xmean), .in_xhatmean(in_xhatmean),
    .calc_x(calc_x), .calc_xhat(calc_xhat), .calc_xmean(calc_xmean),
    .calc_xhatmean(calc_xhatmean), .calc_alpha(calc_alpha), .alpha(alpha),
    .alpha_last(alpha_last)
`ifdef ALPHA_CALC_CTRL_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus controls
  logic en_x = 1, en_xhat = 1, en_xm = 1, en_xhm = 1, en_sink = 1;
  logic en_asrc = 1, en_asnk = 1, rand_mode = 0;
  logic got_x = 1, got_xhat = 1, got_xm = 1, got_xhm = 1, got_a = 1;

  // Bench-side job bookkeeping
  int cfg_job, n_x, n_xhat, n_xm, n_xhm, n_alpha, n_alpha_in, n_last, n_done;
  logic [15:0] qx[$], qxh[$], qxm[$], qxhm[$];
  logic [10:0] qa[$];

  function automatic logic rnd_on(input logic en);
    return en && (!rand_mode || ($urandom_range(0, 3) != 0));
  endfunction

  // Sources, alpha_calc model and downstream sink; all driven just after the rising edge.
  always @(posedge clk) begin
    #1;
    in_x.valid        = rnd_on(en_x);
    in_xhat.valid     = rnd_on(en_xhat);
    in_xmean.valid    = rnd_on(en_xm);
    in_xhatmean.valid = rnd_on(en_xhm);
    calc_x.ready        = rnd_on(en_sink);
    calc_xhat.ready     = rnd_on(en_sink);
    calc_xmean.ready    = rnd_on(en_sink);
    calc_xhatmean.ready = rnd_on(en_sink);
    calc_alpha.valid  = rnd_on(en_asrc);
    alpha.ready       = rnd_on(en_asnk);
    if (got_x)   begin in_x.data        = 16'($urandom); got_x   = 1'b0; end
    if (got_xhat) begin in_xhat.data    = 16'($urandom); got_xhat = 1'b0; end
    if (got_xm)  begin in_xmean.data    = 16'($urandom); got_xm  = 1'b0; end
    if (got_xhm) begin in_xhatmean.data = 16'($urandom); got_xhm = 1'b0; end
    if (got_a)   begin calc_alpha.data  = 10'($urandom); got_a   = 1'b0; end
  end

  // Monitor: sample at the falling edge; transfers complete at the following rising edge.
  always @(negedge clk) begin
    logic fx, fxh;
    logic [10:0] e;
    fx  = calc_x.valid & calc_x.ready;
    fxh = calc_xhat.valid & calc_xhat.ready;
`ifdef ALPHA_CALC_CTRL_STATS_EN
    if (busy && n_xm == n_alpha + 1 && n_xhm == n_alpha + 1 &&
        !(n_x == 4 * (n_alpha + 1) && n_xhat == 4 * (n_alpha + 1)) && !fx && !fxh)
      exp_stall++;
`endif
    if (in_x.valid && in_x.ready)               begin qx.push_back(in_x.data);          got_x = 1'b1; end
    if (in_xhat.valid && in_xhat.ready)         begin qxh.push_back(in_xhat.data);      got_xhat = 1'b1; end
    if (in_xmean.valid && in_xmean.ready)       begin qxm.push_back(in_xmean.data);     got_xm = 1'b1; end
    if (in_xhatmean.valid && in_xhatmean.ready) begin qxhm.push_back(in_xhatmean.data); got_xhm = 1'b1; end
    if (fx) begin
      if (qx.size() == 0) check("x_orphan", 1, 0); else check("x_data", calc_x.data, qx.pop_front());
      n_x++;
    end
    if (fxh) begin
      if (qxh.size() == 0) check("xhat_orphan", 1, 0); else check("xhat_data", calc_xhat.data, qxh.pop_front());
      n_xhat++;
    end
    if (calc_xmean.valid && calc_xmean.ready) begin
      if (qxm.size() == 0) check("xmean_orphan", 1, 0); else check("xmean_data", calc_xmean.data, qxm.pop_front());
      n_xm++;
    end
    if (calc_xhatmean.valid && calc_xhatmean.ready) begin
      if (qxhm.size() == 0) check("xhm_orphan", 1, 0); else check("xhm_data", calc_xhatmean.data, qxhm.pop_front());
      n_xhm++;
    end
    if (calc_alpha.valid && calc_alpha.ready) begin
      qa.push_back({(n_alpha_in == cfg_job - 1), calc_alpha.data});
      n_alpha_in++;
      got_a = 1'b1;
    end
    if (alpha.valid && alpha.ready) begin
      if (qa.size() == 0) check("alpha_orphan", 1, 0);
      else begin
        e = qa.pop_front();
        check("alpha_data", alpha.data, e[9:0]);
        check("alpha_last", alpha_last, e[10]);
      end
      check("blk_x_cnt", n_x, 4 * (n_alpha + 1));
      check("blk_xhat_cnt", n_xhat, 4 * (n_alpha + 1));
      check("blk_mean_cnt", n_xm, n_alpha + 1);
      if (alpha_last) n_last++;
      n_alpha++;
    end
    if (done) n_done++;
  end

  task automatic start_job(input int blocks);
    @(posedge clk); #2;
    cfg_job = blocks; n_x = 0; n_xhat = 0; n_xm = 0; n_xhm = 0;
    n_alpha = 0; n_alpha_in = 0; n_last = 0; n_done = 0;
`ifdef ALPHA_CALC_CTRL_STATS_EN
    exp_stall = 0;
`endif
    start = 1'b1; cfg_blocks = 16'(blocks);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    int d0 = n_done;
    while (n_done == d0 && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check("done_seen", 32'(n_done > d0), 1);
    check("busy_at_done", busy, 1);
    @(negedge clk); #1;
    check("busy_after", busy, 0);
    check("done_pulse_len", done, 0);
  endtask

  task automatic job_checks(input int blocks);
    check("xmean_total", n_xm, blocks);
    check("xhm_total", n_xhm, blocks);
    check("x_total", n_x, 4 * blocks);
    check("xhat_total", n_xhat, 4 * blocks);
    check("alpha_total", n_alpha, blocks);
    check("last_total", n_last, (blocks > 0) ? 1 : 0);
    check("done_total", n_done, 1);
    check("sb_empty", qx.size() + qxh.size() + qxm.size() + qxhm.size() + qa.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_rdy"}, {in_x.ready, in_xhat.ready, in_xmean.ready, in_xhatmean.ready}, 0);
    check({tag, "_calc_vld"}, {calc_x.valid, calc_xhat.valid, calc_xmean.valid, calc_xhatmean.valid}, 0);
    check({tag, "_alpha"}, {alpha.valid, calc_alpha.ready, alpha_last}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [9:0] a0;
    int m0;
    rst = 1'b1; start = 1'b0; cfg_blocks = '0; cfg_job = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
`ifdef ALPHA_CALC_CTRL_STATS_EN
    check("reset_stall", stall_cycles, 0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    // Basic 3-block job, everything flowing
    start_job(3);
    wait_done(200);
    job_checks(3);

    // Zero-block job: done with no transfers
    start_job(0);
    wait_done(2);
    job_checks(0);

    // xhat withheld while x completes its block
    en_xhat = 1'b0;
    start_job(1);
    c = 0;
    while (n_x < 4 && c < 30) begin @(negedge clk); #1; c++; end
    check("x_reached_n", n_x, 4);
    repeat (5) @(negedge clk);
    #1;
    check("x_stops_at_n", n_x, 4);
    check("xhat_held", n_xhat, 0);
    check("no_alpha_early", {alpha.valid, 32'(n_alpha)}, 0);
    en_xhat = 1'b1;
    wait_done(100);
    job_checks(1);
`ifdef ALPHA_CALC_CTRL_STATS_EN
    check("stall_cycles", stall_cycles, exp_stall);
`endif

    // start while busy is ignored
    start_job(2);
    repeat (3) @(posedge clk);
    #2 start = 1'b1; cfg_blocks = 16'd7;
    @(posedge clk); #2 start = 1'b0;
    wait_done(300);
    job_checks(2);

    // reset mid-STREAM abandons the job
    start_job(2);
    c = 0;
    while (n_x < 2 && c < 30) begin @(negedge clk); #1; c++; end
    check("mid_stream_x", 32'(n_x >= 2), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    qx.delete(); qxh.delete(); qxm.delete(); qxhm.delete(); qa.delete();
    m0 = n_done;
    repeat (4) @(negedge clk);
    check("no_done_after_rst", n_done, m0);
    check("idle_after_rst", busy, 0);
    start_job(2);
    wait_done(200);
    job_checks(2);

    // downstream back-pressure in ALPHA
    en_asnk = 1'b0;
    start_job(2);
    c = 0;
    while (!alpha.valid && c < 60) begin @(negedge clk); #1; c++; end
    check("alpha_valid_seen", alpha.valid, 1);
    a0 = alpha.data;
    m0 = n_xm;
    repeat (10) begin
      @(negedge clk); #1;
      check("alpha_held", alpha.valid, 1);
      check("alpha_stable", alpha.data, a0);
      check("no_mean_xfer", {calc_xmean.valid, calc_xhatmean.valid, 32'(n_xm - m0)}, 0);
    end
    en_asnk = 1'b1;
    wait_done(200);
    job_checks(2);

    // random valid/ready on every stream
    rand_mode = 1'b1;
    start_job(4);
    wait_done(2000);
    job_checks(4);
`ifdef ALPHA_CALC_CTRL_STATS_EN
    check("stall_cycles_rand", stall_cycles, exp_stall);
`endif
    rand_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
